heartbeat_pattern_gen: RTL and testbench

Parametrised successor to the board heartbeat block. It drives NUM_LEDS LEDs with one of four selectable patterns: blink, chase, PWM breathe and lub-dub heartbeat. A prescaler plus phase counter sets the beat rate, and a one-cycle beat strobe is exported. It sits at the DE1-SoC top level between CLOCK_50/KEY/SW and LEDR, and is reusable wherever a liveness indicator is needed.

---
 rtl/heartbeat_pattern_gen_pkg.sv | 20 ++
 rtl/heartbeat_pattern_gen_if.sv | 17 +
 rtl/heartbeat_de1soc_top.sv | 30 +++
 rtl/heartbeat_tick_div.sv | 34 +++
 rtl/heartbeat_pattern_gen.sv | 95 +++++++++
 tb/tb_heartbeat_pattern_gen.sv | 154 +++++++++++++++
 6 files changed

// File: rtl/heartbeat_pattern_gen_pkg.sv
// Shared mode encodings and board constants for the heartbeat LED generator family.
// Pure definitions: no logic, no latency, no flow control.
package heartbeat_pkg;

  localparam int unsigned MODE_W           = 2;
  localparam int unsigned DEFAULT_TICK_DIV = 195313;  // 50 MHz / 195313 ~= 256 ticks/s

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK     = 2'd0,
    MODE_CHASE     = 2'd1,
    MODE_BREATHE   = 2'd2,
    MODE_HEARTBEAT = 2'd3
  } hb_mode_e;

  // Lub-dub: on during the 1st and 3rd eighths of a beat.
  function automatic logic hb_pulse(input logic [2:0] top3);
    return (top3 == 3'b000) || (top3 == 3'b010);
  endfunction

endpackage

// File: rtl/heartbeat_pattern_gen_if.sv
// Control/status bundle between a heartbeat generator and whatever drives or observes it.
// Plain wires: no latency, no flow control.
interface heartbeat_pattern_gen_if
  import heartbeat_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 10,
  parameter int unsigned PWM_BITS = 8
);
  logic                enable;
  logic [MODE_W-1:0]   mode;
  logic [NUM_LEDS-1:0] led;
  logic                beat;
  logic [PWM_BITS-1:0] phase;

  modport master (output enable, output mode, input led, input beat, input phase);
  modport slave  (input enable, input mode, output led, output beat, output phase);
endinterface

// File: rtl/heartbeat_de1soc_top.sv
// DE1-SoC pin mapping: KEY[0] resets, SW[1:0] picks the pattern, SW[9] enables, LEDR shows it.
// Adds no registers of its own; no flow control.
module heartbeat_de1soc_top
  import heartbeat_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);
  heartbeat_pattern_gen_if #(.NUM_LEDS(10), .PWM_BITS(8)) hb_if ();

  assign hb_if.enable = SW[9];
  assign hb_if.mode   = SW[MODE_W-1:0];
  assign LEDR         = hb_if.led;

  heartbeat_pattern_gen #(
    .TICK_DIV (DEFAULT_TICK_DIV),
    .PWM_BITS (8),
    .NUM_LEDS (10)
  ) u_heartbeat (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY[0]),
    .hb       (hb_if.slave)
  );

  // Pins and debug outputs the board does not route anywhere.
  logic unused_pins;
  assign unused_pins = ^{KEY[3:1], SW[8:2], hb_if.beat, hb_if.phase};
endmodule

// File: rtl/heartbeat_tick_div.sv
// Prescaler: free-running 0..TICK_DIV-1 counter that flags its last count as a tick.
// tick_o is combinational from the counter; counter and tick freeze while en_i is low.
module heartbeat_tick_div
  import heartbeat_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc_q, presc_d;

  assign tick_o = en_i && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (en_i) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
endmodule

// File: rtl/heartbeat_pattern_gen.sv
// Liveness LED driver: blink / chase / breathe / lub-dub patterns plus a beat strobe.
// led and beat are registered (one cycle behind the counters); enable low freezes state.
module heartbeat_pattern_gen
  import heartbeat_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned NUM_LEDS = 10
) (
  input  logic                    CLOCK_50,
  input  logic                    KEY0,
  heartbeat_pattern_gen_if.slave  hb
);
  localparam int unsigned      POS_W    = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  logic                tick;
  logic                wrap;
  logic [PWM_BITS-1:0] phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] tri_lvl;
  logic [POS_W-1:0]    pos_q, pos_d;
  hb_mode_e            mode_q, mode_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                beat_q, beat_d;

  heartbeat_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk_i  (CLOCK_50),
    .rst_ni (KEY0),
    .en_i   (hb.enable),
    .tick_o (tick)
  );

  always_comb begin
    phase_d   = phase_q;
    pwm_cnt_d = pwm_cnt_q;
    pos_d     = pos_q;
    mode_d    = mode_q;
    wrap      = tick && (phase_q == '1);
    if (hb.enable) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
    if (tick) begin
      phase_d = phase_q + 1'b1;
    end
    // Mode is sampled only at the beat boundary so patterns never tear mid-beat.
    if (wrap) begin
      mode_d = hb_mode_e'(hb.mode);
      pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    end
    beat_d = wrap;
  end

  always_comb begin
    tri_lvl = phase_q << 1;
    if (phase_q[PWM_BITS-1]) begin
      tri_lvl = ~tri_lvl;
    end
    led_d = '0;
    if (hb.enable) begin
      case (mode_q)
        MODE_BLINK:     led_d = {NUM_LEDS{~phase_q[PWM_BITS-1]}};
        MODE_CHASE:     led_d = NUM_LEDS'(1) << pos_q;
        // Strict compare keeps tri_lvl==0 fully dark.
        MODE_BREATHE:   led_d = {NUM_LEDS{pwm_cnt_q < tri_lvl}};
        MODE_HEARTBEAT: led_d = {NUM_LEDS{hb_pulse(phase_q[PWM_BITS-1 -: 3])}};
        default:        led_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      phase_q   <= '0;
      pwm_cnt_q <= '0;
      pos_q     <= '0;
      mode_q    <= MODE_BLINK;
      led_q     <= '0;
      beat_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pwm_cnt_q <= pwm_cnt_d;
      pos_q     <= pos_d;
      mode_q    <= mode_d;
      led_q     <= led_d;
      beat_q    <= beat_d;
    end
  end

  assign hb.led   = led_q;
  assign hb.beat  = beat_q;
  assign hb.phase = phase_q;
endmodule

// File: tb/tb_heartbeat_pattern_gen.sv
// Directed bench for heartbeat_pattern_gen at TICK_DIV=4, PWM_BITS=4, NUM_LEDS=10 (64-clock beat).
module tb_heartbeat_pattern_gen;
  import heartbeat_pkg::*;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned PWM_BITS = 4;
  localparam int unsigned NUM_LEDS = 10;

  logic CLOCK_50 = 1'b0;
  logic KEY0     = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int edges = 0;   // rising edges since the last reset release

  heartbeat_pattern_gen_if #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(PWM_BITS)) hb_if ();

  heartbeat_pattern_gen #(
    .TICK_DIV (TICK_DIV),
    .PWM_BITS (PWM_BITS),
    .NUM_LEDS (NUM_LEDS)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .hb       (hb_if.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [9:0] led, input logic beat,
                          input logic [3:0] phase);
    check_val({tag, ".led"},   32'(hb_if.led),   32'(led));
    check_val({tag, ".beat"},  32'(hb_if.beat),  32'(beat));
    check_val({tag, ".phase"}, 32'(hb_if.phase), 32'(phase));
  endtask

  // Advance to just after rising edge k (counted from reset release), then sample.
  task automatic adv_to(input int k);
    while (edges < k) begin
      @(posedge CLOCK_50);
      edges++;
    end
    #1;
  endtask

  task automatic expect_at(input int k, input logic [9:0] led, input logic beat,
                           input logic [3:0] phase);
    adv_to(k);
    chk_outs($sformatf("e%0d", k), led, beat, phase);
  endtask

  task automatic reset_cycle();
    KEY0 = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk_outs("reset", 10'h000, 1'b0, 4'd0);
    @(negedge CLOCK_50);
    KEY0  = 1'b1;
    edges = 0;
  endtask

  initial begin
    hb_if.enable = 1'b1;
    hb_if.mode   = MODE_BLINK;

    // BLINK from reset: on for phases 0-7, beat every 64 edges.
    reset_cycle();
    expect_at(1,   10'h3FF, 1'b0, 4'd0);
    expect_at(3,   10'h3FF, 1'b0, 4'd0);
    expect_at(4,   10'h3FF, 1'b0, 4'd1);
    expect_at(32,  10'h3FF, 1'b0, 4'd8);
    expect_at(33,  10'h000, 1'b0, 4'd8);
    expect_at(63,  10'h000, 1'b0, 4'd15);
    expect_at(64,  10'h000, 1'b1, 4'd0);
    expect_at(65,  10'h3FF, 1'b0, 4'd0);
    expect_at(128, 10'h000, 1'b1, 4'd0);
    expect_at(129, 10'h3FF, 1'b0, 4'd0);

    // HEARTBEAT takes over at the wrap on edge 192.
    hb_if.mode = MODE_HEARTBEAT;
    expect_at(193, 10'h3FF, 1'b0, 4'd0);
    expect_at(200, 10'h3FF, 1'b0, 4'd2);
    expect_at(201, 10'h000, 1'b0, 4'd2);

    // Switch back to BLINK mid-beat: lub-dub continues until the edge-256 beat.
    hb_if.mode = MODE_BLINK;
    expect_at(205, 10'h000, 1'b0, 4'd3);
    expect_at(209, 10'h3FF, 1'b0, 4'd4);
    expect_at(217, 10'h000, 1'b0, 4'd6);
    expect_at(256, 10'h000, 1'b1, 4'd0);
    expect_at(257, 10'h3FF, 1'b0, 4'd0);
    expect_at(265, 10'h3FF, 1'b0, 4'd2);
    expect_at(270, 10'h3FF, 1'b0, 4'd3);

    // Freeze for 37 edges (271..307); the timeline then resumes shifted by 37.
    hb_if.enable = 1'b0;
    expect_at(271, 10'h000, 1'b0, 4'd3);
    expect_at(290, 10'h000, 1'b0, 4'd3);
    expect_at(307, 10'h000, 1'b0, 4'd3);
    hb_if.enable = 1'b1;
    expect_at(308, 10'h3FF, 1'b0, 4'd3);
    expect_at(309, 10'h3FF, 1'b0, 4'd4);

    // BREATHE captured at the shifted wrap on edge 357.
    hb_if.mode = MODE_BREATHE;
    expect_at(356, 10'h000, 1'b0, 4'd15);
    expect_at(357, 10'h000, 1'b1, 4'd0);
    expect_at(358, 10'h000, 1'b0, 4'd0);   // phase 0: level 0, dark
    expect_at(361, 10'h000, 1'b0, 4'd1);   // still phase-0 inputs, pwm 3
    expect_at(374, 10'h3FF, 1'b0, 4'd4);   // phase 4 level 8, pwm 0
    expect_at(387, 10'h3FF, 1'b0, 4'd7);   // phase 7 level 14, pwm 13
    expect_at(388, 10'h000, 1'b0, 4'd7);   // phase 7 level 14, pwm 14
    expect_at(393, 10'h3FF, 1'b0, 4'd9);   // phase 8 level 15, pwm 3
    expect_at(410, 10'h3FF, 1'b0, 4'd13);  // phase 13 level 5, pwm 4
    expect_at(411, 10'h000, 1'b0, 4'd13);  // phase 13 level 5, pwm 5
    expect_at(421, 10'h000, 1'b1, 4'd0);

    // CHASE: first beat is BLINK (mode captured at first wrap), then one-hot walks.
    hb_if.mode = MODE_CHASE;
    reset_cycle();
    expect_at(1,   10'h3FF, 1'b0, 4'd0);
    expect_at(64,  10'h000, 1'b1, 4'd0);
    expect_at(65,  10'h002, 1'b0, 4'd0);
    expect_at(129, 10'h004, 1'b0, 4'd0);
    expect_at(577, 10'h200, 1'b0, 4'd0);
    expect_at(640, 10'h200, 1'b1, 4'd0);
    expect_at(641, 10'h001, 1'b0, 4'd0);
    expect_at(650, 10'h001, 1'b0, 4'd2);

    // Asynchronous reset between edges.
    #2;
    KEY0 = 1'b0;
    #1;
    chk_outs("async_rst", 10'h000, 1'b0, 4'd0);
    @(negedge CLOCK_50);
    KEY0  = 1'b1;
    edges = 0;
    expect_at(1,  10'h3FF, 1'b0, 4'd0);
    expect_at(63, 10'h000, 1'b0, 4'd15);
    expect_at(64, 10'h000, 1'b1, 4'd0);
    expect_at(65, 10'h002, 1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
